// File: rtl/pll_clk_mon.sv
// PLL output-clock monitor: counts synchronized mon_in rises over a gate window of clk,
// range-checks each count and asserts locked after LOCK_WINDOWS good windows in a row.
// Optional stall detector enabled by defining PLL_CLK_MON_STUCK_EN.
module pll_clk_mon #(
    parameter int GATE_CYCLES  = 24000,
    parameter int CNT_W        = 16,
    parameter int EXP_MIN      = 9900,
    parameter int EXP_MAX      = 10100,
    parameter int LOCK_WINDOWS = 4,
    parameter int STUCK_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mon_in,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             meas_valid,
    output logic             in_range,
    output logic             locked,
    output logic             stuck
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam int LOCK_W = $clog2(LOCK_WINDOWS + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MIN   = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(EXP_MAX);
    localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_WINDOWS);

    if (GATE_CYCLES < 2 || LOCK_WINDOWS < 1 || STUCK_CYCLES < 1) begin : g_bad_param
        $error("pll_clk_mon: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

    state_t            state;
    logic              sync1, sync2, sync_prev;
    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [LOCK_W-1:0] lock_cnt;

    logic              mon_rise;
    logic [CNT_W-1:0]  edge_nxt;
    logic [LOCK_W-1:0] lock_nxt;
    logic              win_ok;

    assign mon_rise = sync2 & ~sync_prev;
    // Edge counter saturates instead of wrapping so a runaway clock still reads out of range.
    assign edge_nxt = (mon_rise && edge_cnt != '1) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign lock_nxt = (lock_cnt == LOCK_FULL) ? lock_cnt : lock_cnt + LOCK_W'(1);
    assign win_ok   = (edge_nxt >= CNT_MIN) && (edge_nxt <= CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= mon_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

`ifdef PLL_CLK_MON_STUCK_EN
    localparam int STALL_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_FULL = STALL_W'(STUCK_CYCLES);
    logic [STALL_W-1:0] stall_cnt;
    logic               stall_hit;
    assign stall_hit = en && (state != IDLE) && !mon_rise && (stall_cnt >= STALL_FULL - STALL_W'(1));
`else
    assign stuck = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            lock_cnt   <= '0;
            freq_cnt   <= '0;
            meas_valid <= 1'b0;
            in_range   <= 1'b0;
            locked     <= 1'b0;
`ifdef PLL_CLK_MON_STUCK_EN
            stall_cnt  <= '0;
            stuck      <= 1'b0;
`endif
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                    in_range <= 1'b0;
                    if (en) state <= MEASURE;
                end
                MEASURE, REPORT: begin
                    if (!en) begin
                        state    <= IDLE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        lock_cnt <= '0;
                        locked   <= 1'b0;
                        in_range <= 1'b0;
                    end else if (state == MEASURE && gate_cnt == GATE_LAST) begin
                        state      <= REPORT;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        freq_cnt   <= edge_nxt;
                        meas_valid <= 1'b1;
                        in_range   <= win_ok;
                        if (win_ok) begin
                            lock_cnt <= lock_nxt;
                            locked   <= (lock_nxt == LOCK_FULL);
                        end else begin
                            lock_cnt <= '0;
                            locked   <= 1'b0;
                        end
                    end else begin
                        // REPORT doubles as cycle 0 of the next window.
                        state    <= MEASURE;
                        gate_cnt <= gate_cnt + GATE_W'(1);
                        edge_cnt <= edge_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef PLL_CLK_MON_STUCK_EN
            if (state == IDLE || !en) begin
                stall_cnt <= '0;
                stuck     <= 1'b0;
            end else if (mon_rise) begin
                stall_cnt <= '0;
                stuck     <= 1'b0;
            end else if (stall_cnt != STALL_FULL) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
                if (stall_cnt == STALL_FULL - STALL_W'(1)) stuck <= 1'b1;
            end
            // A stall drops lock immediately, overriding any window result.
            if (stall_hit) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pll_clk_mon.sv
// Directed bench for pll_clk_mon: reset, nominal lock, drift, abort, saturation
// and (with PLL_CLK_MON_STUCK_EN) stall detection.
module tb_pll_clk_mon;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        mon_in = 1'b0;
    logic        en2 = 1'b0;
    logic        mon2 = 1'b0;
    logic [15:0] freq_cnt;
    logic        meas_valid, in_range, locked, stuck;
    logic [5:0]  freq_cnt2;
    logic        meas_valid2, in_range2, locked2, stuck2;

    int half = 25;
    bit mon_run = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    pll_clk_mon #(
        .GATE_CYCLES(1000), .CNT_W(16), .EXP_MIN(190), .EXP_MAX(210),
        .LOCK_WINDOWS(4), .STUCK_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mon_in(mon_in),
        .freq_cnt(freq_cnt), .meas_valid(meas_valid), .in_range(in_range),
        .locked(locked), .stuck(stuck)
    );

    pll_clk_mon #(
        .GATE_CYCLES(1000), .CNT_W(6), .EXP_MIN(190), .EXP_MAX(210),
        .LOCK_WINDOWS(4), .STUCK_CYCLES(100)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en2), .mon_in(mon2),
        .freq_cnt(freq_cnt2), .meas_valid(meas_valid2), .in_range(in_range2),
        .locked(locked2), .stuck(stuck2)
    );

    always #5 clk = ~clk;

    // mon_in transitions stay 2 or 7 time units past a multiple of 10, away from clk edges.
    initial begin
        #2;
        forever begin
            if (mon_run) begin
                mon_in = 1'b1; #(half);
                mon_in = 1'b0; #(half);
            end else begin
                mon_in = 1'b0; #5;
            end
        end
    end

    initial begin
        #2;
        forever begin
            mon2 = 1'b1; #10;
            mon2 = 1'b0; #10;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(input int max_cyc, output int n);
        n = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (meas_valid) begin n = i; break; end
        end
    endtask

    task automatic wait_pulse2(input int max_cyc, output int n);
        n = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (meas_valid2) begin n = i; break; end
        end
    endtask

    task automatic count_pulses(input int cyc, output int c);
        c = 0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            if (meas_valid) c++;
        end
    endtask

    initial begin
        int n;
        int c;
        logic [15:0] saved;

        repeat (3) @(negedge clk);
        check("rst_freq_cnt", 32'(freq_cnt), 0);
        check("rst_meas_valid", 32'(meas_valid), 0);
        check("rst_in_range", 32'(in_range), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_stuck", 32'(stuck), 0);

        rst_n = 1'b1;
        mon_run = 1'b1;
        count_pulses(1000, c);
        check("idle_no_pulse", c, 0);

        // Saturation: period-2 input gives 500 edges, clipped to 63 in 6 bits.
        en2 = 1'b1;
        wait_pulse2(1100, n);
        check("sat_latency", n, 1001);
        check("sat_freq_cnt", 32'(freq_cnt2), 63);
        check("sat_in_range", 32'(in_range2), 0);

        // Nominal lock at period 5.
        en = 1'b1;
        wait_pulse(1100, n);
        check("nom1_latency", n, 1001);
        check("nom1_cnt_ok", 32'(freq_cnt >= 199 && freq_cnt <= 201), 1);
        check("nom1_in_range", 32'(in_range), 1);
        check("nom1_locked", 32'(locked), 0);
        for (int k = 2; k <= 4; k++) begin
            wait_pulse(1100, n);
            check($sformatf("nom%0d_period", k), n, 1000);
            check($sformatf("nom%0d_cnt_ok", k), 32'(freq_cnt >= 199 && freq_cnt <= 201), 1);
            check($sformatf("nom%0d_locked", k), 32'(locked), (k == 4) ? 1 : 0);
        end
        check("nom_stuck", 32'(stuck), 0);
        @(negedge clk);
        check("pulse_one_cycle", 32'(meas_valid), 0);
        check("lock_held", 32'(locked), 1);

        // Drift to period 4.
        half = 20;
        wait_pulse(1100, n);
        check("drift_cnt_ok", 32'(freq_cnt >= 245 && freq_cnt <= 255), 1);
        check("drift_in_range", 32'(in_range), 0);
        check("drift_locked", 32'(locked), 0);
        half = 25;
        for (int k = 1; k <= 4; k++) begin
            wait_pulse(1100, n);
            check($sformatf("relock%0d_in_range", k), 32'(in_range), 1);
            if (k >= 3) check($sformatf("relock%0d_locked", k), 32'(locked), (k == 4) ? 1 : 0);
        end

`ifdef PLL_CLK_MON_STUCK_EN
        mon_run = 1'b0;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (stuck) begin n = i; break; end
        end
        check("stuck_delay_ok", 32'(n >= 90 && n <= 110), 1);
        check("stuck_locked", 32'(locked), 0);
        mon_run = 1'b1;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (!stuck) begin n = i; break; end
        end
        check("unstuck_fast", 32'(n >= 1 && n <= 9), 1);
`endif

        // Abort mid-window.
        repeat (500) @(negedge clk);
        saved = freq_cnt;
        en = 1'b0;
        @(negedge clk);
        check("abort_locked", 32'(locked), 0);
        check("abort_in_range", 32'(in_range), 0);
        check("abort_freq_cnt", 32'(freq_cnt), 32'(saved));
        check("abort_pulse_now", 32'(meas_valid), 0);
        count_pulses(1100, c);
        check("abort_no_pulse", c, 0);
        en = 1'b1;
        wait_pulse(1100, n);
        check("reen_latency", n, 1001);
        check("reen_in_range", 32'(in_range), 1);
        check("reen_locked", 32'(locked), 0);

        // Asynchronous reset mid-run.
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_freq_cnt", 32'(freq_cnt), 0);
        check("arst_in_range", 32'(in_range), 0);
        check("arst_meas_valid", 32'(meas_valid), 0);
        check("arst_sat_freq_cnt", 32'(freq_cnt2), 0);
        en = 1'b0;
        en2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_pulses(1000, c);
        check("post_rst_no_pulse", c, 0);
        check("post_rst_locked", 32'(locked), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
